// File: rtl/vm_session_arbiter.sv
// vm_session_arbiter: round-robin session scheduler in front of a single vending-machine core.
// It grants one customer panel at a time and pulses a credit clear at session start. During
// the session it forwards only the owner's valid coin codes. The session ends on dispense,
// abandonment (owner drops req) or inactivity timeout.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-low reset
//   req          - level request per panel (bit i = panel i)
//   coin_in      - per-panel coin codes, panel i at [2i+1:2i]; 00 none, 01 nickel, 10 dime, 11 bad
//   vm_dispense  - dispense indication from the core
//   gnt          - registered one-hot grant
//   vm_coin      - coin code forwarded to the core (owner's valid codes only, SESSION only)
//   vm_clr       - one-cycle credit clear, coincides with the first grant cycle
//   busy         - high whenever the scheduler is not idle
//   timeout_flag - one-cycle pulse during the DONE cycle of an inactivity release
module vm_session_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] coin_in,
    input  logic               vm_dispense,
    output logic [N_REQ-1:0]   gnt,
    output logic [1:0]         vm_coin,
    output logic               vm_clr,
    output logic               busy,
    output logic               timeout_flag
);

    localparam int unsigned OwnW = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [OwnW-1:0] LastRst = OwnW'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StClear, StSession, StDone} state_e;

    state_e            state_q, state_d;
    logic [OwnW-1:0]   owner_q, owner_d;
    logic [OwnW-1:0]   last_q, last_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              to_q, to_d;

    logic [OwnW-1:0]    pick;
    logic               found;
    int unsigned        arb_idx;
    logic [2*N_REQ-1:0] coin_shift;
    logic [1:0]         own_coin;
    logic               coin_valid;

    // Round-robin pick: first requester at or after last+1, wrapping.
    always_comb begin
        pick    = last_q;
        found   = 1'b0;
        arb_idx = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            arb_idx = (32'(last_q) + off) % N_REQ;
            if (!found && req[arb_idx]) begin
                pick  = OwnW'(arb_idx);
                found = 1'b1;
            end
        end
    end

    // Owner's coin; 01 and 10 are valid, 00 and 11 both count as no coin.
    always_comb begin
        coin_shift = coin_in >> {owner_q, 1'b0};
        own_coin   = coin_shift[1:0];
        coin_valid = own_coin[0] ^ own_coin[1];
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    owner_d = pick;
                    gnt_d   = N_REQ'(1) << pick;
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = StSession;
            end
            StSession: begin
                if (coin_valid) begin
                    cnt_d = '0;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Dispense beats timeout beats abandon; a coin defeats the timeout.
                if (vm_dispense) begin
                    state_d = StDone;
                end else if (!coin_valid && cnt_q == CntLast) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                end else if (!req[owner_q]) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = '0;
                last_d  = owner_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= LastRst;
            gnt_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt          = gnt_q;
    assign vm_coin      = (state_q == StSession && coin_valid) ? own_coin : 2'b00;
    assign vm_clr       = (state_q == StClear);
    assign busy         = (state_q != StIdle);
    assign timeout_flag = to_q;

endmodule
